// File: rtl/sauria_pkg.sv
// Shared constants for the SAURIA configuration register block:
// section sizes, CTRL/status bit positions and the sequencer state encoding.
package sauria_pkg;

    localparam int TOTAL_REGS_CON = 2;
    localparam int TOTAL_REGS_ACT = 3;
    localparam int TOTAL_REGS_WEI = 2;
    localparam int TOTAL_REGS_OUT = 2;

    localparam int WORD_W = 32;

    // CTRL write decode
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    // CTRL read (status) layout
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } cfg_state_e;

    function automatic logic in_range(input int addr, input int base, input int n);
        return (addr >= base) && (addr < base + n);
    endfunction

endpackage

// File: rtl/sauria_cfg_bank.sv
// N-word double-buffered register bank: software writes the shadow copy,
// a one-cycle commit copies the whole shadow into the active copy.
module sauria_cfg_bank
    import sauria_pkg::*;
#(
    parameter int N  = 1,
    parameter int AW = 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_wen,
    input  logic [AW-1:0]       i_widx,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic                i_commit,
    input  logic [AW-1:0]       i_ridx,
    output logic [WORD_W-1:0]   o_rdata,
    output logic [WORD_W*N-1:0] o_active
);

    logic [WORD_W-1:0] shadow_q [N];
    logic [WORD_W-1:0] active_q [N];

    // NOTE: both copies are reset because downstream logic may sample the
    // active config straight out of reset; they are flops, not a RAM macro.
    // NOTE: sequential state uses non-blocking assignments only, so the
    // commit copy below sees the pre-edge shadow value.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < N; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (i_wen && (i_widx == AW'(k))) begin
                    shadow_q[k] <= i_wdata;
                end
                if (i_commit) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    // NOTE: default assignment first so no path through the loop infers a latch.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < N; k++) begin
            if (i_ridx == AW'(k)) begin
                o_rdata = shadow_q[k];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_active
        assign o_active[WORD_W*g +: WORD_W] = active_q[g];
    end

endmodule

// File: rtl/sauria_cfg_regs.sv
// SAURIA configuration register file: CTRL word at address 0, four
// double-buffered config sections behind it, and the start/run/done sequencer.
module sauria_cfg_regs
    import sauria_pkg::*;
#(
    parameter int  CON_REGS = sauria_pkg::TOTAL_REGS_CON,
    parameter int  ACT_REGS = sauria_pkg::TOTAL_REGS_ACT,
    parameter int  WEI_REGS = sauria_pkg::TOTAL_REGS_WEI,
    parameter int  OUT_REGS = sauria_pkg::TOTAL_REGS_OUT,
    localparam int NREGS    = 1 + CON_REGS + ACT_REGS + WEI_REGS + OUT_REGS,
    localparam int ADDR_W   = $clog2(NREGS)
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_cfg_wen,
    input  logic [ADDR_W-1:0]          i_cfg_waddr,
    input  logic [WORD_W-1:0]          i_cfg_wdata,
    output logic                       o_cfg_wready,
    input  logic                       i_cfg_ren,
    input  logic [ADDR_W-1:0]          i_cfg_raddr,
    output logic [WORD_W-1:0]          o_cfg_rdata,
    output logic                       o_cfg_rvalid,
    input  logic                       i_core_done,
    output logic [WORD_W*CON_REGS-1:0] o_cfg_con,
    output logic [WORD_W*ACT_REGS-1:0] o_cfg_act,
    output logic [WORD_W*WEI_REGS-1:0] o_cfg_wei,
    output logic [WORD_W*OUT_REGS-1:0] o_cfg_out,
    output logic                       o_start,
    output logic                       o_busy,
    output logic                       o_done_irq
);

    localparam int CON_BASE = 1;
    localparam int ACT_BASE = CON_BASE + CON_REGS;
    localparam int WEI_BASE = ACT_BASE + ACT_REGS;
    localparam int OUT_BASE = WEI_BASE + WEI_REGS;

    cfg_state_e        state_q, state_d;
    logic              done_sticky_q, done_sticky_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q;

    logic              wr_acc, ctrl_wr, commit;
    logic              con_wen, act_wen, wei_wen, out_wen;
    logic [WORD_W-1:0] con_rdata, act_rdata, wei_rdata, out_rdata;
    logic [WORD_W-1:0] status;

    assign o_cfg_wready = (state_q != ST_COMMIT);
    assign o_start      = (state_q == ST_COMMIT);
    assign o_busy       = (state_q == ST_RUN);
    assign o_done_irq   = (state_q == ST_DONE);
    assign commit       = (state_q == ST_COMMIT);

    assign wr_acc  = i_cfg_wen && o_cfg_wready;
    assign ctrl_wr = wr_acc && (i_cfg_waddr == '0);
    assign con_wen = wr_acc && in_range(int'(i_cfg_waddr), CON_BASE, CON_REGS);
    assign act_wen = wr_acc && in_range(int'(i_cfg_waddr), ACT_BASE, ACT_REGS);
    assign wei_wen = wr_acc && in_range(int'(i_cfg_waddr), WEI_BASE, WEI_REGS);
    assign out_wen = wr_acc && in_range(int'(i_cfg_waddr), OUT_BASE, OUT_REGS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ctrl_wr && i_cfg_wdata[CTRL_START_BIT]) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RUN;
            ST_RUN:    if (i_core_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The DONE set is applied last so it wins over a same-cycle clear.
    always_comb begin
        done_sticky_d = done_sticky_q;
        if (ctrl_wr && i_cfg_wdata[CTRL_CLEAR_BIT]) done_sticky_d = 1'b0;
        if (state_q == ST_DONE)                     done_sticky_d = 1'b1;
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = o_busy;
        status[STAT_DONE_BIT] = done_sticky_q;
    end

    // Read data comes from the pre-edge shadow, so a same-address write
    // in the same cycle returns the old value.
    always_comb begin
        rdata_d = rdata_q;
        if (i_cfg_ren) begin
            if (i_cfg_raddr == '0)                                   rdata_d = status;
            else if (in_range(int'(i_cfg_raddr), CON_BASE, CON_REGS)) rdata_d = con_rdata;
            else if (in_range(int'(i_cfg_raddr), ACT_BASE, ACT_REGS)) rdata_d = act_rdata;
            else if (in_range(int'(i_cfg_raddr), WEI_BASE, WEI_REGS)) rdata_d = wei_rdata;
            else if (in_range(int'(i_cfg_raddr), OUT_BASE, OUT_REGS)) rdata_d = out_rdata;
            else                                                     rdata_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= ST_IDLE;
            done_sticky_q <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_sticky_q <= done_sticky_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= i_cfg_ren;
        end
    end

    assign o_cfg_rdata  = rdata_q;
    assign o_cfg_rvalid = rvalid_q;

    sauria_cfg_bank #(.N(CON_REGS), .AW(ADDR_W)) u_bank_con (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_wen    (con_wen),
        .i_widx   (i_cfg_waddr - ADDR_W'(CON_BASE)),
        .i_wdata  (i_cfg_wdata),
        .i_commit (commit),
        .i_ridx   (i_cfg_raddr - ADDR_W'(CON_BASE)),
        .o_rdata  (con_rdata),
        .o_active (o_cfg_con)
    );

    sauria_cfg_bank #(.N(ACT_REGS), .AW(ADDR_W)) u_bank_act (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_wen    (act_wen),
        .i_widx   (i_cfg_waddr - ADDR_W'(ACT_BASE)),
        .i_wdata  (i_cfg_wdata),
        .i_commit (commit),
        .i_ridx   (i_cfg_raddr - ADDR_W'(ACT_BASE)),
        .o_rdata  (act_rdata),
        .o_active (o_cfg_act)
    );

    sauria_cfg_bank #(.N(WEI_REGS), .AW(ADDR_W)) u_bank_wei (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_wen    (wei_wen),
        .i_widx   (i_cfg_waddr - ADDR_W'(WEI_BASE)),
        .i_wdata  (i_cfg_wdata),
        .i_commit (commit),
        .i_ridx   (i_cfg_raddr - ADDR_W'(WEI_BASE)),
        .o_rdata  (wei_rdata),
        .o_active (o_cfg_wei)
    );

    sauria_cfg_bank #(.N(OUT_REGS), .AW(ADDR_W)) u_bank_out (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_wen    (out_wen),
        .i_widx   (i_cfg_waddr - ADDR_W'(OUT_BASE)),
        .i_wdata  (i_cfg_wdata),
        .i_commit (commit),
        .i_ridx   (i_cfg_raddr - ADDR_W'(OUT_BASE)),
        .o_rdata  (out_rdata),
        .o_active (o_cfg_out)
    );

endmodule

// File: tb/tb_sauria_cfg_regs.sv
// Directed bench for sauria_cfg_regs: register map, double buffering,
// start/run/done sequencing and reset abort, with hand-computed expectations.
module tb_sauria_cfg_regs;

    logic        i_clk;
    logic        i_rstn;
    logic        i_cfg_wen;
    logic [3:0]  i_cfg_waddr;
    logic [31:0] i_cfg_wdata;
    logic        o_cfg_wready;
    logic        i_cfg_ren;
    logic [3:0]  i_cfg_raddr;
    logic [31:0] o_cfg_rdata;
    logic        o_cfg_rvalid;
    logic        i_core_done;
    logic [63:0] o_cfg_con;
    logic [95:0] o_cfg_act;
    logic [63:0] o_cfg_wei;
    logic [63:0] o_cfg_out;
    logic        o_start;
    logic        o_busy;
    logic        o_done_irq;

    int n_checks = 0;
    int n_pass   = 0;

    sauria_cfg_regs #(
        .CON_REGS(2), .ACT_REGS(3), .WEI_REGS(2), .OUT_REGS(2)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_cfg_wen    (i_cfg_wen),
        .i_cfg_waddr  (i_cfg_waddr),
        .i_cfg_wdata  (i_cfg_wdata),
        .o_cfg_wready (o_cfg_wready),
        .i_cfg_ren    (i_cfg_ren),
        .i_cfg_raddr  (i_cfg_raddr),
        .o_cfg_rdata  (o_cfg_rdata),
        .o_cfg_rvalid (o_cfg_rvalid),
        .i_core_done  (i_core_done),
        .o_cfg_con    (o_cfg_con),
        .o_cfg_act    (o_cfg_act),
        .o_cfg_wei    (o_cfg_wei),
        .o_cfg_out    (o_cfg_out),
        .o_start      (o_start),
        .o_busy       (o_busy),
        .o_done_irq   (o_done_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Hold the write until accepted; reports how many edges that took.
    task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data, output int edges);
        logic acc;
        acc   = 1'b0;
        edges = 0;
        i_cfg_wen   = 1'b1;
        i_cfg_waddr = addr;
        i_cfg_wdata = data;
        for (int i = 0; i < 8; i++) begin
            acc = o_cfg_wready;
            tick();
            edges++;
            if (acc) break;
        end
        i_cfg_wen = 1'b0;
        if (!acc) check("write_accept_timeout", 32'(acc), 32'h1);
    endtask

    task automatic cfg_read(input logic [3:0] addr, output logic [31:0] data);
        i_cfg_ren   = 1'b1;
        i_cfg_raddr = addr;
        tick();
        i_cfg_ren = 1'b0;
        check("rvalid", 32'(o_cfg_rvalid), 32'h1);
        data = o_cfg_rdata;
    endtask

    initial begin
        logic [31:0] rd;
        int          edges;
        int          n_start;

        i_rstn      = 1'b0;
        i_cfg_wen   = 1'b0;
        i_cfg_waddr = '0;
        i_cfg_wdata = '0;
        i_cfg_ren   = 1'b0;
        i_cfg_raddr = '0;
        i_core_done = 1'b0;

        // Reset values
        #12;
        check("rst_wready", 32'(o_cfg_wready), 32'h1);
        check("rst_start",  32'(o_start),      32'h0);
        check("rst_busy",   32'(o_busy),       32'h0);
        check("rst_irq",    32'(o_done_irq),   32'h0);
        check("rst_rvalid", 32'(o_cfg_rvalid), 32'h0);
        check("rst_rdata",  o_cfg_rdata,       32'h0);
        tick();
        i_rstn = 1'b1;
        tick();

        // Read CTRL after reset; config outputs all zero
        cfg_read(4'd0, rd);
        check("ctrl_after_rst", rd, 32'h0);
        check("wready_idle", 32'(o_cfg_wready), 32'h1);
        check("con_zero", (o_cfg_con == '0) ? 32'h1 : 32'h0, 32'h1);
        check("act_zero", (o_cfg_act == '0) ? 32'h1 : 32'h0, 32'h1);
        check("wei_zero", (o_cfg_wei == '0) ? 32'h1 : 32'h0, 32'h1);
        check("out_zero", (o_cfg_out == '0) ? 32'h1 : 32'h0, 32'h1);
        tick();
        check("rvalid_drop", 32'(o_cfg_rvalid), 32'h0);
        check("rdata_hold", o_cfg_rdata, 32'h0);

        // Shadow write to ACT word 1 (addr 4) does not reach active
        cfg_write(4'd4, 32'hA5A5_0001, edges);
        check("act_before_commit", o_cfg_act[63:32], 32'h0);
        cfg_read(4'd4, rd);
        check("shadow_rd_addr4", rd, 32'hA5A5_0001);

        // Start: COMMIT for one cycle, then RUN with active updated
        cfg_write(4'd0, 32'h1, edges);
        check("commit_start", 32'(o_start), 32'h1);
        check("commit_wready", 32'(o_cfg_wready), 32'h0);
        check("commit_busy", 32'(o_busy), 32'h0);
        tick();
        check("run_start_low", 32'(o_start), 32'h0);
        check("run_busy", 32'(o_busy), 32'h1);
        check("act_w1_commit", o_cfg_act[63:32], 32'hA5A5_0001);
        check("act_w0_commit", o_cfg_act[31:0], 32'h0);

        // In RUN: shadow write to OUT word 0, start ignored and not queued
        cfg_write(4'd8, 32'h0000_1234, edges);
        check("out_unchanged_run", o_cfg_out[31:0], 32'h0);
        cfg_write(4'd0, 32'h1, edges);
        n_start = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_start) n_start++;
            tick();
        end
        check("no_second_start", 32'(n_start), 32'h0);
        check("still_busy", 32'(o_busy), 32'h1);

        // Core done -> DONE for one cycle -> IDLE with sticky set
        i_core_done = 1'b1;
        tick();
        i_core_done = 1'b0;
        check("done_irq", 32'(o_done_irq), 32'h1);
        check("done_busy", 32'(o_busy), 32'h0);
        tick();
        check("done_irq_1cyc", 32'(o_done_irq), 32'h0);
        cfg_read(4'd0, rd);
        check("ctrl_sticky", rd, 32'h2);

        // core_done outside RUN is ignored
        i_core_done = 1'b1;
        tick();
        i_core_done = 1'b0;
        check("done_ignored_irq", 32'(o_done_irq), 32'h0);
        check("done_ignored_busy", 32'(o_busy), 32'h0);

        // Same-cycle read and write of one address returns the old value
        i_cfg_wen   = 1'b1;
        i_cfg_waddr = 4'd4;
        i_cfg_wdata = 32'hDEAD_BEEF;
        i_cfg_ren   = 1'b1;
        i_cfg_raddr = 4'd4;
        tick();
        i_cfg_wen = 1'b0;
        i_cfg_ren = 1'b0;
        check("rw_same_old", o_cfg_rdata, 32'hA5A5_0001);
        cfg_read(4'd4, rd);
        check("rw_same_new", rd, 32'hDEAD_BEEF);

        // Start+clear together: sticky cleared and commit happens
        cfg_write(4'd0, 32'h3, edges);
        check("sc_start", 32'(o_start), 32'h1);
        check("sc_wready_low", 32'(o_cfg_wready), 32'h0);
        cfg_write(4'd9, 32'h0000_5555, edges);
        check("commit_write_edges", 32'(edges), 32'h2);
        check("out_w0_commit", o_cfg_out[31:0], 32'h0000_1234);
        check("out_w1_not_committed", o_cfg_out[63:32], 32'h0);
        check("act_w1_recommit", o_cfg_act[63:32], 32'hDEAD_BEEF);
        cfg_read(4'd9, rd);
        check("late_write_landed", rd, 32'h0000_5555);
        cfg_read(4'd0, rd);
        check("ctrl_cleared_busy", rd, 32'h1);

        // Out-of-range address: write ignored, read returns zero
        cfg_write(4'd12, 32'hFFFF_FFFF, edges);
        cfg_read(4'd12, rd);
        check("oob_read", rd, 32'h0);
        cfg_read(4'd1, rd);
        check("oob_no_alias_con", rd, 32'h0);
        check("oob_busy_kept", 32'(o_busy), 32'h1);
        check("oob_out_kept", o_cfg_out[31:0], 32'h0000_1234);

        // Reset mid-RUN aborts immediately with no done pulse
        i_rstn = 1'b0;
        #1;
        check("abort_busy", 32'(o_busy), 32'h0);
        check("abort_irq", 32'(o_done_irq), 32'h0);
        check("abort_out", o_cfg_out[31:0], 32'h0);
        check("abort_wready", 32'(o_cfg_wready), 32'h1);
        tick();
        i_rstn = 1'b1;
        n_start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_done_irq || o_busy) n_start++;
        end
        check("abort_quiet", 32'(n_start), 32'h0);
        cfg_read(4'd0, rd);
        check("abort_ctrl", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
